// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch front end: FSM states, redirect priorities,
// default boot/exception vectors and the sequential PC increment.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_IDLE,
        ST_WAIT
    } fetch_state_e;

    // Larger value wins when two redirects compete.
    typedef enum logic [2:0] {
        PRIO_NONE = 3'd0,
        PRIO_BR   = 3'd1,
        PRIO_JUMP = 3'd2,
        PRIO_JR   = 3'd3,
        PRIO_EXC  = 3'd4
    } redir_prio_e;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'hBFC0_0380;
    localparam logic [31:0] PC_INC           = 32'd4;

endpackage

// File: rtl/pc_fetch_sequencer_next_pc_sel.sv
// Combinational next-PC source selection: priority mux, J-target build, JR alignment
// check and the pc+4 link adder.
module next_pc_sel
    import mips_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic [31:0] pc_i,
    input  logic        exc_i,
    input  logic        jr_i,
    input  logic [31:0] jr_target_i,
    input  logic        jump_i,
    input  logic [25:0] instr_index_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    output logic [31:0] pc_plus4_o,
    output logic        redir_o,
    output logic [2:0]  redir_prio_o,
    output logic [31:0] redir_target_o,
    output logic        misalign_o
);

    redir_prio_e prio;
    logic [31:0] j_target;

    assign pc_plus4_o = pc_i + PC_INC;
    assign j_target   = {pc_plus4_o[31:28], instr_index_i, 2'b00};

    always_comb begin
        prio           = PRIO_NONE;
        redir_target_o = pc_plus4_o;
        misalign_o     = 1'b0;
        if (exc_i) begin
            prio           = PRIO_EXC;
            redir_target_o = EXC_VECTOR;
        end else if (jr_i) begin
            prio           = PRIO_JR;
            misalign_o     = |jr_target_i[1:0];
            redir_target_o = misalign_o ? EXC_VECTOR : jr_target_i;
        end else if (jump_i) begin
            prio           = PRIO_JUMP;
            redir_target_o = j_target;
        end else if (br_taken_i) begin
            prio           = PRIO_BR;
            redir_target_o = br_target_i;
        end
    end

    assign redir_prio_o = prio;
    assign redir_o      = (prio != PRIO_NONE);

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and instruction-fetch sequencer: BOOT/IDLE/WAIT fetch FSM with a
// req/ack handshake and a one-entry pending-redirect register for outstanding fetches.
module pc_fetch_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        jump_i,
    input  logic [25:0] instr_index_i,
    input  logic        jr_i,
    input  logic [31:0] jr_target_i,
    input  logic        exc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    output logic        fetch_valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        redirect_o,
    output logic        misalign_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         pend_valid_q, pend_valid_d;
    logic [2:0]   pend_prio_q, pend_prio_d;
    logic [31:0]  pend_target_q, pend_target_d;

    logic [31:0]  pc_plus4;
    logic         sel_redir;
    logic [2:0]   sel_prio;
    logic [31:0]  sel_target;
    logic         sel_misalign;
    logic         redir_live;
    logic         ack_live;
    logic         take_new;
    logic [31:0]  win_target;

    next_pc_sel #(.EXC_VECTOR(EXC_VECTOR)) u_next_pc_sel (
        .pc_i           (pc_q),
        .exc_i          (exc_i),
        .jr_i           (jr_i),
        .jr_target_i    (jr_target_i),
        .jump_i         (jump_i),
        .instr_index_i  (instr_index_i),
        .br_taken_i     (br_taken_i),
        .br_target_i    (br_target_i),
        .pc_plus4_o     (pc_plus4),
        .redir_o        (sel_redir),
        .redir_prio_o   (sel_prio),
        .redir_target_o (sel_target),
        .misalign_o     (sel_misalign)
    );

    // BOOT ignores redirects so the cycle after reset stays quiet.
    assign redir_live = sel_redir & (state_q != ST_BOOT);
    assign ack_live   = imem_ack_i & (state_q == ST_WAIT);
    assign take_new   = redir_live & (~pend_valid_q | (sel_prio >= pend_prio_q));
    assign win_target = take_new ? sel_target : pend_target_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_BOOT;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_VECTOR;
            pend_valid_q  <= 1'b0;
            pend_prio_q   <= '0;
            pend_target_q <= '0;
        end else begin
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_prio_q   <= pend_prio_d;
            pend_target_q <= pend_target_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BOOT: state_d = ST_IDLE;
            ST_IDLE: if (!stall_i) state_d = ST_WAIT;
            ST_WAIT: if (ack_live && stall_i) state_d = ST_IDLE;
            default: state_d = ST_BOOT;
        endcase
    end

    // The fetch address is frozen while a request is outstanding; redirects wait in pend_*.
    always_comb begin
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_prio_d   = pend_prio_q;
        pend_target_d = pend_target_q;
        if (state_q == ST_IDLE) begin
            if (redir_live) pc_d = sel_target;
        end else if (state_q == ST_WAIT) begin
            if (ack_live) begin
                pc_d         = (pend_valid_q | redir_live) ? win_target : pc_plus4;
                pend_valid_d = 1'b0;
            end else if (take_new) begin
                pend_valid_d  = 1'b1;
                pend_prio_d   = sel_prio;
                pend_target_d = sel_target;
            end
        end
    end

    always_comb begin
        imem_req_o    = (state_q == ST_WAIT);
        imem_addr_o   = pc_q;
        pc_o          = pc_q;
        pc_plus4_o    = pc_plus4;
        fetch_valid_o = ack_live & ~(pend_valid_q | redir_live);
        redirect_o    = ((state_q == ST_IDLE) & redir_live) | (ack_live & (pend_valid_q | redir_live));
        misalign_o    = sel_misalign & (state_q != ST_BOOT);
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: directed vector table, hand sequences for
// multi-cycle corners, and randomized traffic against a queue-based reference model.
module tb_pc_fetch_sequencer;

    localparam logic [31:0] RST_V = 32'hBFC0_0000;
    localparam logic [31:0] EXC_V = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i, br_taken_i, jump_i, jr_i, exc_i, imem_ack_i;
    logic [31:0] br_target_i, jr_target_i;
    logic [25:0] instr_index_i;
    logic        imem_req_o, fetch_valid_o, redirect_o, misalign_o;
    logic [31:0] imem_addr_o, pc_o, pc_plus4_o;

    int n_checks = 0;
    int n_fail   = 0;

    pc_fetch_sequencer #(.RESET_VECTOR(RST_V), .EXC_VECTOR(EXC_V)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .br_taken_i    (br_taken_i),
        .br_target_i   (br_target_i),
        .jump_i        (jump_i),
        .instr_index_i (instr_index_i),
        .jr_i          (jr_i),
        .jr_target_i   (jr_target_i),
        .exc_i         (exc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .fetch_valid_o (fetch_valid_o),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .redirect_o    (redirect_o),
        .misalign_o    (misalign_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] br_t;
        logic        jump;
        logic [25:0] idx;
        logic        jr;
        logic [31:0] jr_t;
        logic        exc;
        logic        ack;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic        e_redir;
        logic        e_mis;
        logic        e_valid;
    } vec_t;

    typedef struct {
        int          rank;
        logic [31:0] tgt;
    } redir_t;

    vec_t   vecs[14];
    redir_t pendq[$];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t base(input logic stall, input logic ack, input logic e_req,
                                  input logic [31:0] e_addr, input logic [31:0] e_pc,
                                  input logic e_redir, input logic e_mis, input logic e_valid);
        vec_t v;
        v = '{default: '0};
        v.stall = stall;  v.ack = ack;
        v.e_req = e_req;  v.e_addr = e_addr; v.e_pc = e_pc;
        v.e_redir = e_redir; v.e_mis = e_mis; v.e_valid = e_valid;
        return v;
    endfunction

    task automatic clear_inputs();
        stall_i = 1'b0; br_taken_i = 1'b0; br_target_i = '0; jump_i = 1'b0;
        instr_index_i = '0; jr_i = 1'b0; jr_target_i = '0; exc_i = 1'b0; imem_ack_i = 1'b0;
    endtask

    task automatic check_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                             input logic [31:0] e_pc, input logic e_redir, input logic e_mis,
                             input logic e_valid);
        logic [31:0] e_p4;
        e_p4 = e_pc + 32'd4;
        chk1($sformatf("%s.req", tag), imem_req_o, e_req);
        if (e_req) chk32($sformatf("%s.addr", tag), imem_addr_o, e_addr);
        chk32($sformatf("%s.pc", tag), pc_o, e_pc);
        chk32($sformatf("%s.pc4", tag), pc_plus4_o, e_p4);
        chk1($sformatf("%s.redirect", tag), redirect_o, e_redir);
        chk1($sformatf("%s.misalign", tag), misalign_o, e_mis);
        chk1($sformatf("%s.valid", tag), fetch_valid_o, e_valid);
    endtask

    // Called at posedge+1; leaves the bench at the following posedge+1.
    task automatic run_cycle(input vec_t v, input string tag);
        stall_i = v.stall; br_taken_i = v.br; br_target_i = v.br_t; jump_i = v.jump;
        instr_index_i = v.idx; jr_i = v.jr; jr_target_i = v.jr_t; exc_i = v.exc;
        imem_ack_i = v.ack;
        @(negedge clk);
        check_all(tag, v.e_req, v.e_addr, v.e_pc, v.e_redir, v.e_mis, v.e_valid);
        @(posedge clk);
        #1 clear_inputs();
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        vec_t v;
        logic        m_boot, m_busy, n_boot, n_busy;
        logic [31:0] m_pc, n_pc, nt, t;
        logic        mis, has_pend, e_redir, e_valid;
        int          nr;

        // Directed table: boot, back-to-back fetches, exc+br pending, JR misalign, J, stall exit.
        vecs[0]  = base(1'b0, 1'b0, 1'b0, 32'h0, 32'hBFC0_0000, 1'b0, 1'b0, 1'b0);
        vecs[1]  = base(1'b0, 1'b0, 1'b0, 32'h0, 32'hBFC0_0000, 1'b0, 1'b0, 1'b0);
        vecs[2]  = base(1'b0, 1'b1, 1'b1, 32'hBFC0_0000, 32'hBFC0_0000, 1'b0, 1'b0, 1'b1);
        vecs[3]  = base(1'b0, 1'b1, 1'b1, 32'hBFC0_0004, 32'hBFC0_0004, 1'b0, 1'b0, 1'b1);
        vecs[4]  = base(1'b0, 1'b1, 1'b1, 32'hBFC0_0008, 32'hBFC0_0008, 1'b0, 1'b0, 1'b1);
        vecs[5]  = base(1'b0, 1'b0, 1'b1, 32'hBFC0_000C, 32'hBFC0_000C, 1'b0, 1'b0, 1'b0);
        vecs[5].exc = 1'b1; vecs[5].br = 1'b1; vecs[5].br_t = 32'h0040_0100;
        vecs[6]  = base(1'b1, 1'b1, 1'b1, 32'hBFC0_000C, 32'hBFC0_000C, 1'b1, 1'b0, 1'b0);
        vecs[7]  = base(1'b1, 1'b0, 1'b0, 32'h0, 32'hBFC0_0380, 1'b1, 1'b1, 1'b0);
        vecs[7].jr = 1'b1; vecs[7].jr_t = 32'h0040_0002;
        vecs[8]  = base(1'b1, 1'b0, 1'b0, 32'h0, 32'hBFC0_0380, 1'b0, 1'b0, 1'b0);
        vecs[9]  = base(1'b1, 1'b0, 1'b0, 32'h0, 32'hBFC0_0380, 1'b1, 1'b0, 1'b0);
        vecs[9].jump = 1'b1; vecs[9].idx = 26'h010_0000;
        vecs[10] = base(1'b0, 1'b0, 1'b0, 32'h0, 32'hB040_0000, 1'b1, 1'b0, 1'b0);
        vecs[10].br = 1'b1; vecs[10].br_t = 32'h0040_0010;
        vecs[11] = base(1'b0, 1'b0, 1'b1, 32'h0040_0010, 32'h0040_0010, 1'b0, 1'b0, 1'b0);
        vecs[12] = base(1'b1, 1'b1, 1'b1, 32'h0040_0010, 32'h0040_0010, 1'b0, 1'b0, 1'b1);
        vecs[13] = base(1'b1, 1'b0, 1'b0, 32'h0, 32'h0040_0014, 1'b0, 1'b0, 1'b0);

        do_reset();
        for (int i = 0; i < 14; i++) run_cycle(vecs[i], $sformatf("vec%0d", i));

        // J target from pc 0040_0010 in IDLE.
        v = base(1'b1, 1'b0, 1'b0, 32'h0, 32'h0040_0014, 1'b1, 1'b0, 1'b0);
        v.br = 1'b1; v.br_t = 32'h0040_0010; run_cycle(v, "j.setup");
        v = base(1'b1, 1'b0, 1'b0, 32'h0, 32'h0040_0010, 1'b1, 1'b0, 1'b0);
        v.jump = 1'b1; v.idx = 26'h010_0000; run_cycle(v, "j.redir");
        run_cycle(base(1'b1, 1'b0, 1'b0, 32'h0, 32'h0040_0000, 1'b0, 1'b0, 1'b0), "j.after");

        // Branch while a fetch is outstanding, ack three cycles late.
        v = base(1'b0, 1'b0, 1'b0, 32'h0, 32'h0040_0000, 1'b1, 1'b0, 1'b0);
        v.br = 1'b1; v.br_t = 32'h0040_0020; run_cycle(v, "pend.enter");
        v = base(1'b0, 1'b0, 1'b1, 32'h0040_0020, 32'h0040_0020, 1'b0, 1'b0, 1'b0);
        v.br = 1'b1; v.br_t = 32'h0040_0100; run_cycle(v, "pend.c1");
        run_cycle(base(1'b0, 1'b0, 1'b1, 32'h0040_0020, 32'h0040_0020, 1'b0, 1'b0, 1'b0), "pend.c2");
        run_cycle(base(1'b0, 1'b0, 1'b1, 32'h0040_0020, 32'h0040_0020, 1'b0, 1'b0, 1'b0), "pend.c3");
        run_cycle(base(1'b0, 1'b1, 1'b1, 32'h0040_0020, 32'h0040_0020, 1'b1, 1'b0, 1'b0), "pend.ack");

        // Stall held while the request is outstanding.
        for (int i = 0; i < 4; i++)
            run_cycle(base(1'b1, 1'b0, 1'b1, 32'h0040_0100, 32'h0040_0100, 1'b0, 1'b0, 1'b0),
                      $sformatf("stall.hold%0d", i));
        run_cycle(base(1'b1, 1'b1, 1'b1, 32'h0040_0100, 32'h0040_0100, 1'b0, 1'b0, 1'b1), "stall.ack");
        run_cycle(base(1'b1, 1'b0, 1'b0, 32'h0, 32'h0040_0104, 1'b0, 1'b0, 1'b0), "stall.idle0");
        run_cycle(base(1'b1, 1'b0, 1'b0, 32'h0, 32'h0040_0104, 1'b0, 1'b0, 1'b0), "stall.idle1");
        run_cycle(base(1'b0, 1'b0, 1'b0, 32'h0, 32'h0040_0104, 1'b0, 1'b0, 1'b0), "stall.release");
        run_cycle(base(1'b0, 1'b0, 1'b1, 32'h0040_0104, 32'h0040_0104, 1'b0, 1'b0, 1'b0), "stall.req");

        // PC wrap at the top of the address space, then reset mid-fetch.
        run_cycle(base(1'b1, 1'b1, 1'b1, 32'h0040_0104, 32'h0040_0104, 1'b0, 1'b0, 1'b1), "wrap.exit");
        v = base(1'b0, 1'b0, 1'b0, 32'h0, 32'h0040_0108, 1'b1, 1'b0, 1'b0);
        v.br = 1'b1; v.br_t = 32'hFFFF_FFFC; run_cycle(v, "wrap.br");
        run_cycle(base(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1), "wrap.ack");
        run_cycle(base(1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0), "wrap.next");
        #2 rst_n = 1'b0;
        #1;
        chk1("async_rst.req", imem_req_o, 1'b0);
        chk32("async_rst.pc", pc_o, RST_V);
        chk1("async_rst.valid", fetch_valid_o, 1'b0);
        do_reset();

        // Randomized traffic against the reference model.
        m_boot = 1'b1; m_busy = 1'b0; m_pc = RST_V;
        pendq.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            stall_i       = ($urandom_range(0, 3) == 0);
            exc_i         = ($urandom_range(0, 24) == 0);
            jr_i          = ($urandom_range(0, 14) == 0);
            jump_i        = ($urandom_range(0, 11) == 0);
            br_taken_i    = ($urandom_range(0, 7) == 0);
            instr_index_i = 26'($urandom);
            t = $urandom;
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            jr_target_i = t;
            br_target_i = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : ($urandom & ~32'd3);
            imem_ack_i  = m_busy && ($urandom_range(0, 2) != 0);

            nr = 0; nt = '0; mis = 1'b0;
            if (exc_i) begin
                nr = 4; nt = EXC_V;
            end else if (jr_i) begin
                nr = 3; mis = (jr_target_i % 4) != 0; nt = mis ? EXC_V : jr_target_i;
            end else if (jump_i) begin
                nr = 2; nt = ((m_pc + 32'd4) & 32'hF000_0000) | ({6'd0, instr_index_i} << 2);
            end else if (br_taken_i) begin
                nr = 1; nt = br_target_i;
            end
            if (m_boot) begin
                nr = 0; mis = 1'b0;
            end
            has_pend = (pendq.size() > 0);
            e_valid  = m_busy && imem_ack_i && !has_pend && nr == 0;
            e_redir  = (!m_busy && !m_boot && nr > 0) || (m_busy && imem_ack_i && (has_pend || nr > 0));

            n_boot = 1'b0; n_busy = m_busy; n_pc = m_pc;
            if (m_boot) begin
                n_busy = 1'b0;
            end else if (!m_busy) begin
                if (nr > 0) n_pc = nt;
                n_busy = !stall_i;
            end else if (imem_ack_i) begin
                if (nr > 0 && (!has_pend || nr >= pendq[0].rank)) n_pc = nt;
                else if (has_pend) n_pc = pendq[0].tgt;
                else n_pc = m_pc + 32'd4;
                pendq.delete();
                n_busy = !stall_i;
            end else if (nr > 0 && (!has_pend || nr >= pendq[0].rank)) begin
                pendq.delete();
                pendq.push_back('{nr, nt});
            end

            @(negedge clk);
            check_all($sformatf("rnd%0d", cyc), m_busy, m_pc, m_pc, e_redir, mis, e_valid);
            @(posedge clk);
            #1 clear_inputs();
            m_boot = n_boot; m_busy = n_busy; m_pc = n_pc;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
